rs_issue_scheduler: RTL

RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

---
 rtl/rs_issue_if.sv | 40 ++++
 rtl/rs_issue_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rs_issue_if.sv
// Handshake/bus bundle between the reservation-station wakeup logic and the issue scheduler.
// The master side presents per-entry readiness and tags; the slave side returns one issue slot per unit.
interface rs_issue_if #(
    parameter int SIZE  = 8,
    parameter int TAG_W = 4
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] front_tag;
        logic [TAG_W-1:0] flush_tag;
    } flush_t;

    flush_t                        flush;
    logic [SIZE-1:0]               ready;
    logic [SIZE-1:0]               acu_operation;
    logic [SIZE-1:0][TAG_W-1:0]    entry_tag;
    logic [TAG_W-1:0]              rob_front_tag;
    logic                          alu_ready;
    logic                          cmp_ready;
    logic                          alu_issue_valid;
    logic                          cmp_issue_valid;
    logic [IDX_W-1:0]              alu_issue_idx;
    logic [IDX_W-1:0]              cmp_issue_idx;
    logic [TAG_W-1:0]              alu_issue_tag;
    logic [TAG_W-1:0]              cmp_issue_tag;

    modport master (
        output flush, ready, acu_operation, entry_tag, rob_front_tag, alu_ready, cmp_ready,
        input  alu_issue_valid, cmp_issue_valid, alu_issue_idx, cmp_issue_idx,
               alu_issue_tag, cmp_issue_tag
    );

    modport slave (
        input  flush, ready, acu_operation, entry_tag, rob_front_tag, alu_ready, cmp_ready,
        output alu_issue_valid, cmp_issue_valid, alu_issue_idx, cmp_issue_idx,
               alu_issue_tag, cmp_issue_tag
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue scheduler: picks one ready entry per unit (ALU / CMP) by modular ROB age,
// holds it under backpressure and tracks issued-but-not-freed entries in an in-flight mask.
module rs_issue_scheduler #(
    parameter int SIZE  = 8,
    parameter int TAG_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    rs_issue_if.slave bus
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [SIZE-1:0]  r_in_flight;
    logic             r_alu_valid;
    logic             r_cmp_valid;
    logic [IDX_W-1:0] r_alu_idx;
    logic [IDX_W-1:0] r_cmp_idx;
    logic [TAG_W-1:0] r_alu_tag;
    logic [TAG_W-1:0] r_cmp_tag;

    logic             w_alu_fire;
    logic             w_cmp_fire;
    logic             w_alu_flushed;
    logic             w_cmp_flushed;
    logic [SIZE-1:0]  w_alu_elig;
    logic [SIZE-1:0]  w_cmp_elig;
    logic [SIZE-1:0]  w_flush_hit;
    logic [IDX_W:0]   w_alu_pick;
    logic [IDX_W:0]   w_cmp_pick;
    logic [SIZE-1:0]  w_in_flight_nxt;
    logic             w_alu_valid_nxt;
    logic             w_cmp_valid_nxt;
    logic [IDX_W-1:0] w_alu_idx_nxt;
    logic [IDX_W-1:0] w_cmp_idx_nxt;
    logic [TAG_W-1:0] w_alu_tag_nxt;
    logic [TAG_W-1:0] w_cmp_tag_nxt;

    // The window wraps when the flush tag has rolled past the front tag.
    function automatic logic in_window(input logic [TAG_W-1:0] t,
                                       input logic [TAG_W-1:0] f,
                                       input logic [TAG_W-1:0] ft);
        logic hit;
        if (f <= ft) begin
            hit = (t >= f) && (t < ft);
        end else begin
            hit = (t >= f) || (t < ft);
        end
        return hit;
    endfunction

    // Returns {found, index} of the smallest modular age; strict compare keeps the lowest index on ties.
    function automatic logic [IDX_W:0] pick_oldest(input logic [SIZE-1:0]            elig,
                                                    input logic [SIZE-1:0][TAG_W-1:0] tags,
                                                    input logic [TAG_W-1:0]           front);
        logic             found;
        logic [IDX_W-1:0] best;
        logic [TAG_W-1:0] best_age;
        logic [TAG_W-1:0] age;
        found    = 1'b0;
        best     = {IDX_W{1'b0}};
        best_age = {TAG_W{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            age = tags[i] - front;
            if (elig[i] && (!found || (age < best_age))) begin
                found    = 1'b1;
                best     = IDX_W'(i);
                best_age = age;
            end else begin
                found = found;
            end
        end
        return {found, best};
    endfunction

    assign w_alu_fire    = r_alu_valid & bus.alu_ready;
    assign w_cmp_fire    = r_cmp_valid & bus.cmp_ready;
    assign w_alu_flushed = bus.flush.valid & in_window(r_alu_tag, bus.flush.front_tag, bus.flush.flush_tag);
    assign w_cmp_flushed = bus.flush.valid & in_window(r_cmp_tag, bus.flush.front_tag, bus.flush.flush_tag);
    assign w_alu_pick    = pick_oldest(w_alu_elig, bus.entry_tag, bus.rob_front_tag);
    assign w_cmp_pick    = pick_oldest(w_cmp_elig, bus.entry_tag, bus.rob_front_tag);

    // Per-entry eligibility and flush-window membership.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            w_alu_elig[i]  = bus.ready[i] & ~bus.acu_operation[i] & ~r_in_flight[i]
                           & ~(r_alu_valid & (r_alu_idx == IDX_W'(i)));
            w_cmp_elig[i]  = bus.ready[i] &  bus.acu_operation[i] & ~r_in_flight[i]
                           & ~(r_cmp_valid & (r_cmp_idx == IDX_W'(i)));
            w_flush_hit[i] = bus.flush.valid
                           & in_window(bus.entry_tag[i], bus.flush.front_tag, bus.flush.flush_tag);
        end
    end

    // In-flight mask: freed entries and flushed tags clear, a surviving fire sets (set wins).
    always_comb begin
        w_in_flight_nxt = r_in_flight & bus.ready & ~w_flush_hit;
        if (w_alu_fire && !w_alu_flushed) begin
            w_in_flight_nxt[r_alu_idx] = 1'b1;
        end else begin
            w_in_flight_nxt = w_in_flight_nxt;
        end
        if (w_cmp_fire && !w_cmp_flushed) begin
            w_in_flight_nxt[r_cmp_idx] = 1'b1;
        end else begin
            w_in_flight_nxt = w_in_flight_nxt;
        end
    end

    // Issue slots: during a flush a flushed or consumed slot empties and nothing new is picked.
    always_comb begin
        w_alu_valid_nxt = r_alu_valid;
        w_alu_idx_nxt   = r_alu_idx;
        w_alu_tag_nxt   = r_alu_tag;
        w_cmp_valid_nxt = r_cmp_valid;
        w_cmp_idx_nxt   = r_cmp_idx;
        w_cmp_tag_nxt   = r_cmp_tag;
        if (bus.flush.valid) begin
            w_alu_valid_nxt = r_alu_valid & ~w_alu_flushed & ~w_alu_fire;
            w_cmp_valid_nxt = r_cmp_valid & ~w_cmp_flushed & ~w_cmp_fire;
        end else begin
            if (!r_alu_valid || w_alu_fire) begin
                w_alu_valid_nxt = w_alu_pick[IDX_W];
                w_alu_idx_nxt   = w_alu_pick[IDX_W-1:0];
                w_alu_tag_nxt   = bus.entry_tag[w_alu_pick[IDX_W-1:0]];
            end else begin
                w_alu_valid_nxt = r_alu_valid;
            end
            if (!r_cmp_valid || w_cmp_fire) begin
                w_cmp_valid_nxt = w_cmp_pick[IDX_W];
                w_cmp_idx_nxt   = w_cmp_pick[IDX_W-1:0];
                w_cmp_tag_nxt   = bus.entry_tag[w_cmp_pick[IDX_W-1:0]];
            end else begin
                w_cmp_valid_nxt = r_cmp_valid;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_flight <= {SIZE{1'b0}};
            r_alu_valid <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_alu_idx   <= {IDX_W{1'b0}};
            r_cmp_idx   <= {IDX_W{1'b0}};
            r_alu_tag   <= {TAG_W{1'b0}};
            r_cmp_tag   <= {TAG_W{1'b0}};
        end else begin
            r_in_flight <= w_in_flight_nxt;
            r_alu_valid <= w_alu_valid_nxt;
            r_cmp_valid <= w_cmp_valid_nxt;
            r_alu_idx   <= w_alu_idx_nxt;
            r_cmp_idx   <= w_cmp_idx_nxt;
            r_alu_tag   <= w_alu_tag_nxt;
            r_cmp_tag   <= w_cmp_tag_nxt;
        end
    end

    assign bus.alu_issue_valid = r_alu_valid;
    assign bus.cmp_issue_valid = r_cmp_valid;
    assign bus.alu_issue_idx   = r_alu_idx;
    assign bus.cmp_issue_idx   = r_cmp_idx;
    assign bus.alu_issue_tag   = r_alu_tag;
    assign bus.cmp_issue_tag   = r_cmp_tag;
endmodule
